// File: rtl/adder_pkg.sv
// Shared constants and the capture record for the adder capture block.
// Defining ADDER_CAPTURE_CHECK_EN enables the sum check.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_WIDTH:0]   c;
        logic                     mismatch;
    } capture_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with a registered head; the storage array is
// written at the tail and read one edge ahead into the head register.
module sync_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  entry_t                   wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output entry_t                   rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign wr_ready_o = (count_q != (AW+1)'(DEPTH));
    assign rd_valid_o = (count_q != '0);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;
    assign rd_data_o  = head_q;
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Bypass when the entry being written becomes the new head; when the
        // FIFO goes empty the head register keeps its last value.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wr_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/adder_capture.sv
// Captures adder operand/result samples into a FIFO with stall and error
// counters. Define ADDER_CAPTURE_CHECK_EN to flag samples where c != a + b.
module adder_capture
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH:0]           in_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [WIDTH:0]           out_c,
    output logic                     out_mismatch,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               stall_cnt,
    output logic [7:0]               err_cnt
);

    // Same layout as capture_entry_t, but sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   c;
        logic             mismatch;
    } entry_t;

    entry_t     wr_entry;
    entry_t     head;
    logic       mismatch;
    logic       push;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    sync_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (in_valid),
        .wr_ready_o (in_ready),
        .wr_data_i  (wr_entry),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  (head),
        .count_o    (count)
    );

    assign push = in_valid && in_ready;

    always_comb begin
        wr_entry          = '0;
        wr_entry.a        = in_a;
        wr_entry.b        = in_b;
        wr_entry.c        = in_c;
        wr_entry.mismatch = mismatch;
    end

`ifdef ADDER_CAPTURE_CHECK_EN
    logic [WIDTH:0] sum;
    logic [7:0]     err_cnt_q, err_cnt_d;

    assign sum      = {1'b0, in_a} + {1'b0, in_b};
    assign mismatch = (in_c != sum);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign mismatch = 1'b0;
    assign err_cnt  = 8'd0;
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign out_a        = head.a;
    assign out_b        = head.b;
    assign out_c        = head.c;
    // The stored bit is constant 0 when the check is compiled out.
    assign out_mismatch = head.mismatch;

endmodule

// File: tb/tb_adder_capture.sv
// Directed, table-driven bench for adder_capture (WIDTH=4, DEPTH=8).
// Expectations follow ADDER_CAPTURE_CHECK_EN when it is defined.
module tb_adder_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic [4:0] in_c;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a, out_b;
    logic [4:0] out_c;
    logic       out_mismatch;
    logic [3:0] count;
    logic [7:0] stall_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    adder_capture #(.WIDTH(4), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_c        (out_c),
        .out_mismatch (out_mismatch),
        .count        (count),
        .stall_cnt    (stall_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] c;
        logic       mis;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c);
        in_valid = v;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_c     = 5'(c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_err;
        int q[$];
        logic em;

        vecs[0] = '{a: 4'd15, b: 4'd15, c: 5'd14, mis: 1'b1};
        vecs[1] = '{a: 4'd15, b: 4'd15, c: 5'd30, mis: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  c: 5'd0,  mis: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd9,  c: 5'd16, mis: 1'b0};
        vecs[4] = '{a: 4'd1,  b: 4'd2,  c: 5'd4,  mis: 1'b1};
        vecs[5] = '{a: 4'd8,  b: 4'd8,  c: 5'd0,  mis: 1'b1};
        vecs[6] = '{a: 4'd10, b: 4'd5,  c: 5'd15, mis: 1'b0};

        drive(1'b0, 0, 0, 0);
        do_reset();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_mismatch", out_mismatch, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_c", out_c, 0);
        $display("reset: count=%0d in_ready=%0d out_valid=%0d", count, in_ready, out_valid);

        // Single push, one-edge latency
        drive(1'b1, 3, 5, 8);
        step();
        drive(1'b0, 0, 0, 0);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_c", out_c, 8);
        chk("lat_mismatch", out_mismatch, 0);
        chk("lat_count", count, 1);
        $display("push 3+5=8: out_valid=%0d out_c=%0d count=%0d", out_valid, out_c, count);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lat_pop_count", count, 0);

        // Table of single-entry transactions
        exp_err = 0;
        for (int i = 0; i < 7; i++) begin
`ifdef ADDER_CAPTURE_CHECK_EN
            em = vecs[i].mis;
`else
            em = 1'b0;
`endif
            drive(1'b1, int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].c));
            step();
            drive(1'b0, 0, 0, 0);
            if (em) exp_err++;
            chk("vec_out_valid", out_valid, 1);
            chk("vec_out_a", out_a, int'(vecs[i].a));
            chk("vec_out_b", out_b, int'(vecs[i].b));
            chk("vec_out_c", out_c, int'(vecs[i].c));
            chk("vec_mismatch", out_mismatch, int'(em));
            chk("vec_err_cnt", err_cnt, exp_err);
            $display("vec %0d: a=%0d b=%0d c=%0d mismatch=%0d err_cnt=%0d",
                     i, out_a, out_b, out_c, out_mismatch, err_cnt);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("vec_pop_count", count, 0);
        end

        // Fill to full, stall three cycles, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 1, i + 1);
            step();
        end
        chk("full_count", count, 8);
        chk("full_in_ready", in_ready, 0);
        drive(1'b1, 15, 15, 30);
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 0, 0, 0);
        chk("full_stall", stall_cnt, 3);
        chk("full_hold_a", out_a, 0);
        chk("full_count_after_stall", count, 8);
        $display("full: count=%0d stall_cnt=%0d", count, stall_cnt);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_a", out_a, i);
            $display("drain %0d: out_a=%0d", i, out_a);
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_out_valid", out_valid, 0);

        // Steady state at count=4 across pointer wrap
        do_reset();
        q.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k, 0, k);
            q.push_back(k);
            step();
        end
        chk("steady_fill_count", count, 4);
        out_ready = 1'b1;
        for (int k = 4; k < 24; k++) begin
            drive(1'b1, k % 16, 0, k % 16);
            chk("steady_order", out_a, q[0]);
            $display("steady: push=%0d pop=%0d exp=%0d", k % 16, out_a, q[0]);
            step();
            void'(q.pop_front());
            q.push_back(k % 16);
            chk("steady_count", count, 4);
        end
        drive(1'b0, 0, 0, 0);
        out_ready = 1'b0;

        // Reset mid-operation with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i, 1, 31);
            step();
        end
        chk("prerst_count", count, 5);
        rst = 1'b1;
        drive(1'b1, 9, 9, 18);
        step();
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        chk("midrst_count", count, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_stall", stall_cnt, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_mismatch", out_mismatch, 0);
        chk("midrst_out_a", out_a, 0);
        step();
        chk("midrst_after_count", count, 0);
        $display("mid reset: count=%0d out_valid=%0d", count, out_valid);

        // Stall counter saturation
        drive(1'b1, 1, 1, 2);
        for (int i = 0; i < 8 + 260; i++) step();
        drive(1'b0, 0, 0, 0);
        chk("stall_sat", stall_cnt, 255);
        $display("saturation: stall_cnt=%0d", stall_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_capture.md
ADDER_CAPTURE -- requirements
Module: adder_capture

Interface
REQ-001 Parameter WIDTH, default 4, operand width of the adder under test.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  the a/b/c sample is valid this cycle.
REQ-007 in_ready  output  1  the block accepts a sample this cycle.
REQ-008 in_a, in_b  input  WIDTH  adder operands.
REQ-009 in_c  input  WIDTH+1  adder result.
REQ-010 out_valid  output  1  the head entry is available.
REQ-011 out_ready  input  1  the consumer takes the head entry.
REQ-012 out_a, out_b, out_c  output  WIDTH / WIDTH / WIDTH+1  head entry fields.
REQ-013 out_mismatch  output  1  the head entry failed the sum check.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 stall_cnt  output  8  cycles in which in_valid=1 and in_ready=0.
REQ-016 err_cnt  output  8  number of mismatching samples pushed.

Function
REQ-017 Push: in_valid and in_ready both 1 at a clock edge store {in_a, in_b, in_c, mismatch} at the tail.
REQ-018 in_ready = (count != DEPTH); combinational from state only, never dependent on in_valid.
REQ-019 out_valid = (count != 0); out_* SHALL show the head entry (first-word fall-through), with no combinational path from in_* to out_*.
REQ-020 Pop: out_valid and out_ready both 1 at a clock edge advance the head.
REQ-021 Latency: a sample pushed at edge N SHALL be visible on out_* with out_valid=1 after edge N when the FIFO was empty.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; when full, in_ready=0 blocks the push and only the pop occurs.
REQ-023 Empty: out_ready is ignored and out_* hold their last value; the consumer SHALL NOT rely on that value.
REQ-024 Pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-025 stall_cnt and err_cnt SHALL saturate at 255.
REQ-026 out_* and out_mismatch SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 Reset SHALL set count=0, both pointers=0, in_ready=1, out_valid=0, stall_cnt=0, err_cnt=0, out_mismatch=0, and out_a/out_b/out_c=0.
REQ-028 Assertion of reset mid-operation SHALL discard all stored entries at that edge, and a push in the same cycle is ignored.

Configuration
REQ-029 Macro ADDER_CAPTURE_CHECK_EN defined: at push, mismatch = (in_c != in_a + in_b), computed at WIDTH+1 bits; err_cnt increments on each mismatching push.
REQ-030 Macro ADDER_CAPTURE_CHECK_EN undefined: the check logic is absent, the stored mismatch bit is 0, and err_cnt and out_mismatch are tied to 0; the port list is identical in both builds.

Structure
REQ-031 Package adder_pkg SHALL hold the default WIDTH and DEPTH constants and typedef capture_entry_t (a, b, c, mismatch).
REQ-032 Storage and pointers SHALL be a sub-module sync_fifo parameterised by entry type and DEPTH; adder_capture adds the check logic, the counters, and the port mapping.

Verification
REQ-033 Push a=3, b=5, c=8 with out_ready=0 -> next cycle out_valid=1, out_c=8, out_mismatch=0, count=1.
REQ-034 Push 8 samples (a=i, b=1, c=i+1) with out_ready=0 -> count=8, in_ready=0; hold in_valid 3 more cycles -> stall_cnt=3; drain them -> a=0..7 in order.
REQ-035 Hold the FIFO at count=4 with in_valid=1 and out_ready=1 for 20 cycles -> count stays 4 and the output order matches the input order across pointer wrap.
REQ-036 With CHECK_EN defined, push a=15, b=15, c=14 -> out_mismatch=1, err_cnt=1; push a=15, b=15, c=30 -> out_mismatch=0, err_cnt still 1.
REQ-037 Fill 5 entries, then assert rst for one cycle while in_valid=1 -> count=0, out_valid=0, and the counters read 0.
REQ-038 Without CHECK_EN, repeat the REQ-036 stimulus -> err_cnt=0 and out_mismatch=0 throughout.
